// File: rtl/sp_ram_arbiter.sv
// Two-master request/grant arbiter in front of a single-port SRAM with a one-cycle read latency.
// Steers the winning master onto the SRAM, routes the response back one cycle later, counts conflicts.
module sp_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter bit          RR_ENABLE  = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  p0_req_i,
  output logic                  p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic                  p0_we_i,
  input  logic [3:0]            p0_be_i,
  input  logic [31:0]           p0_wdata_i,
  output logic                  p0_rvalid_o,
  output logic [31:0]           p0_rdata_o,

  input  logic                  p1_req_i,
  output logic                  p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic                  p1_we_i,
  input  logic [3:0]            p1_be_i,
  input  logic [31:0]           p1_wdata_i,
  output logic                  p1_rvalid_o,
  output logic [31:0]           p1_rdata_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,

  input  logic                  cnt_clr_i,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  typedef struct packed {
    logic valid;
    logic id;
  } owner_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic                 last_q;   // id of the most recently granted port
  owner_t               owner_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic both_req;
  logic any_req;
  logic sel_p1;

  // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    both_req = p0_req_i & p1_req_i;
    any_req  = p0_req_i | p1_req_i;
    sel_p1   = p1_req_i;
    if (both_req) begin
      sel_p1 = RR_ENABLE ? ~last_q : 1'b0;
    end
  end

  assign p0_gnt_o = any_req & ~sel_p1;
  assign p1_gnt_o = any_req &  sel_p1;
  assign ram_en_o = p0_gnt_o | p1_gnt_o;

  // Idle cycles drive zeros so the SRAM pins do not toggle with ungranted masters.
  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (p0_gnt_o) begin
      ram_addr_o  = p0_addr_i;
      ram_we_o    = p0_we_i;
      ram_be_o    = p0_be_i;
      ram_wdata_o = p0_wdata_i;
    end else if (p1_gnt_o) begin
      ram_addr_o  = p1_addr_i;
      ram_we_o    = p1_we_i;
      ram_be_o    = p1_be_i;
      ram_wdata_o = p1_wdata_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q  <= 1'b1;
      owner_q <= '0;
    end else begin
      owner_q.valid <= any_req;
      owner_q.id    <= sel_p1;
      if (any_req) begin
        last_q <= sel_p1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (both_req && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign conflict_cnt_o = cnt_q;

  // Responses follow the owner recorded at grant time; writes get an rvalid too.
  assign p0_rvalid_o = owner_q.valid & ~owner_q.id;
  assign p1_rvalid_o = owner_q.valid &  owner_q.id;
  assign p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: round-robin instance with an SRAM model driven from a vector table,
// plus fixed-priority and narrow-counter instances exercised by short hand-written sequences.
module tb_sp_ram_arbiter;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- round-robin instance with SRAM model ----------------
  logic          rr_p0_req, rr_p0_gnt, rr_p0_we, rr_p0_rvalid;
  logic [AW-1:0] rr_p0_addr;
  logic [3:0]    rr_p0_be;
  logic [31:0]   rr_p0_wdata, rr_p0_rdata;
  logic          rr_p1_req, rr_p1_gnt, rr_p1_we, rr_p1_rvalid;
  logic [AW-1:0] rr_p1_addr;
  logic [3:0]    rr_p1_be;
  logic [31:0]   rr_p1_wdata, rr_p1_rdata;
  logic          rr_ram_en, rr_ram_we;
  logic [AW-1:0] rr_ram_addr;
  logic [3:0]    rr_ram_be;
  logic [31:0]   rr_ram_wdata, rr_ram_rdata;
  logic          rr_clr;
  logic [15:0]   rr_cnt;

  sp_ram_arbiter u_rr (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(rr_p0_req), .p0_gnt_o(rr_p0_gnt), .p0_addr_i(rr_p0_addr), .p0_we_i(rr_p0_we),
    .p0_be_i(rr_p0_be), .p0_wdata_i(rr_p0_wdata), .p0_rvalid_o(rr_p0_rvalid), .p0_rdata_o(rr_p0_rdata),
    .p1_req_i(rr_p1_req), .p1_gnt_o(rr_p1_gnt), .p1_addr_i(rr_p1_addr), .p1_we_i(rr_p1_we),
    .p1_be_i(rr_p1_be), .p1_wdata_i(rr_p1_wdata), .p1_rvalid_o(rr_p1_rvalid), .p1_rdata_o(rr_p1_rdata),
    .ram_en_o(rr_ram_en), .ram_addr_o(rr_ram_addr), .ram_we_o(rr_ram_we), .ram_be_o(rr_ram_be),
    .ram_wdata_o(rr_ram_wdata), .ram_rdata_i(rr_ram_rdata),
    .cnt_clr_i(rr_clr), .conflict_cnt_o(rr_cnt)
  );

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (rr_ram_en) begin
      rr_ram_rdata <= mem[rr_ram_addr[7:0]];
      if (rr_ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (rr_ram_be[b]) mem[rr_ram_addr[7:0]][b*8 +: 8] <= rr_ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------- fixed-priority instance ----------------
  logic          fp_p0_req, fp_p0_gnt, fp_p0_rvalid;
  logic          fp_p1_req, fp_p1_gnt, fp_p1_rvalid;
  logic [AW-1:0] fp_p0_addr, fp_p1_addr, fp_ram_addr;
  logic [31:0]   fp_p0_rdata, fp_p1_rdata, fp_ram_wdata;
  logic          fp_ram_en, fp_ram_we;
  logic [3:0]    fp_ram_be;
  logic [15:0]   fp_cnt;

  sp_ram_arbiter #(.RR_ENABLE(1'b0)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(fp_p0_req), .p0_gnt_o(fp_p0_gnt), .p0_addr_i(fp_p0_addr), .p0_we_i(1'b0),
    .p0_be_i(4'hF), .p0_wdata_i(32'h0), .p0_rvalid_o(fp_p0_rvalid), .p0_rdata_o(fp_p0_rdata),
    .p1_req_i(fp_p1_req), .p1_gnt_o(fp_p1_gnt), .p1_addr_i(fp_p1_addr), .p1_we_i(1'b0),
    .p1_be_i(4'hF), .p1_wdata_i(32'h0), .p1_rvalid_o(fp_p1_rvalid), .p1_rdata_o(fp_p1_rdata),
    .ram_en_o(fp_ram_en), .ram_addr_o(fp_ram_addr), .ram_we_o(fp_ram_we), .ram_be_o(fp_ram_be),
    .ram_wdata_o(fp_ram_wdata), .ram_rdata_i(32'hCAFEF00D),
    .cnt_clr_i(1'b0), .conflict_cnt_o(fp_cnt)
  );

  // ---------------- 4-bit counter instance ----------------
  logic          st_p0_req, st_p0_gnt, st_p0_rvalid;
  logic          st_p1_req, st_p1_gnt, st_p1_rvalid;
  logic [AW-1:0] st_ram_addr;
  logic [31:0]   st_p0_rdata, st_p1_rdata, st_ram_wdata;
  logic          st_ram_en, st_ram_we, st_clr;
  logic [3:0]    st_ram_be;
  logic [3:0]    st_cnt;

  sp_ram_arbiter #(.CNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(st_p0_req), .p0_gnt_o(st_p0_gnt), .p0_addr_i(17'h1), .p0_we_i(1'b0),
    .p0_be_i(4'hF), .p0_wdata_i(32'h0), .p0_rvalid_o(st_p0_rvalid), .p0_rdata_o(st_p0_rdata),
    .p1_req_i(st_p1_req), .p1_gnt_o(st_p1_gnt), .p1_addr_i(17'h2), .p1_we_i(1'b0),
    .p1_be_i(4'hF), .p1_wdata_i(32'h0), .p1_rvalid_o(st_p1_rvalid), .p1_rdata_o(st_p1_rdata),
    .ram_en_o(st_ram_en), .ram_addr_o(st_ram_addr), .ram_we_o(st_ram_we), .ram_be_o(st_ram_be),
    .ram_wdata_o(st_ram_wdata), .ram_rdata_i(32'h0),
    .cnt_clr_i(st_clr), .conflict_cnt_o(st_cnt)
  );

  // ---------------- vector table for the round-robin instance ----------------
  typedef struct {
    logic          r0;
    logic [AW-1:0] a0;
    logic          w0;
    logic [3:0]    b0;
    logic [31:0]   d0;
    logic          r1;
    logic [AW-1:0] a1;
    logic          w1;
    logic [3:0]    b1;
    logic [31:0]   d1;
    logic          g0, g1;     // expected grants this cycle
    logic          rv0, rv1;   // expected responses (from previous row's grant)
    logic          chk_rd;     // compare rdata of the responding port
    logic [31:0]   rd;
    logic [15:0]   cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic [AW-1:0] a0, input logic w0, input logic [3:0] b0, input logic [31:0] d0,
    input logic r1, input logic [AW-1:0] a1, input logic w1, input logic [3:0] b1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic rv0, input logic rv1,
    input logic chk_rd, input logic [31:0] rd, input logic [15:0] cnt);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.w0 = w0; v.b0 = b0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.w1 = w1; v.b1 = b1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1;
    v.chk_rd = chk_rd; v.rd = rd; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs[$];

  task automatic idle_rr();
    rr_p0_req = 0; rr_p0_addr = '0; rr_p0_we = 0; rr_p0_be = '0; rr_p0_wdata = '0;
    rr_p1_req = 0; rr_p1_addr = '0; rr_p1_we = 0; rr_p1_be = '0; rr_p1_wdata = '0;
  endtask

  initial begin
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [3:0]    exp_be;
    logic [31:0]   exp_wd;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11223344;
    mem[8'h30] = 32'h30303030;
    mem[8'h40] = 32'h40404040;

    idle_rr();
    rr_clr = 0;
    fp_p0_req = 0; fp_p1_req = 0; fp_p0_addr = 17'h1; fp_p1_addr = 17'h2;
    st_p0_req = 0; st_p1_req = 0; st_clr = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset p0_rvalid", {31'b0, rr_p0_rvalid}, 32'h0);
    check("reset p1_rvalid", {31'b0, rr_p1_rvalid}, 32'h0);
    check("reset p0_rdata", rr_p0_rdata, 32'h0);
    check("reset p1_rdata", rr_p1_rdata, 32'h0);
    check("reset cnt", {16'b0, rr_cnt}, 32'h0);
    check("reset ram_en", {31'b0, rr_ram_en}, 32'h0);
    check("reset ram_addr", {15'b0, rr_ram_addr}, 32'h0);
    // Grant is combinational even while reset is held
    rr_p0_req = 1; rr_p0_addr = 17'h10;
    #1;
    check("gnt in reset", {31'b0, rr_p0_gnt}, 32'h1);
    check("ram_addr in reset", {15'b0, rr_ram_addr}, 32'h10);
    idle_rr();
    @(negedge clk);
    rst = 0;

    //            p0: req addr   we be    wdata          p1: req addr  we be      wdata         g0 g1 rv0 rv1 chk rd            cnt
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         0, 17'h00, 0, 4'h0,    32'h0,        0, 0, 0,  0,  1, 32'h0,        0));
    vecs.push_back(mk(1, 17'h10, 0, 4'hF, 32'h12345678,  0, 17'h00, 0, 4'h0,    32'h0,        1, 0, 0,  0,  1, 32'h0,        0));
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         0, 17'h00, 0, 4'h0,    32'h0,        0, 0, 1,  0,  1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         1, 17'h20, 1, 4'b0011, 32'hA5A5A5A5, 0, 1, 0,  0,  1, 32'h0,        0));
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         1, 17'h20, 0, 4'hF,    32'h0,        0, 1, 0,  1,  0, 32'h0,        0));
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         0, 17'h00, 0, 4'h0,    32'h0,        0, 0, 0,  1,  1, 32'h1122A5A5, 0));
    vecs.push_back(mk(1, 17'h30, 0, 4'hF, 32'h0,         1, 17'h40, 0, 4'hC,    32'h0,        1, 0, 0,  0,  1, 32'h0,        0));
    vecs.push_back(mk(1, 17'h30, 0, 4'hF, 32'h0,         1, 17'h40, 0, 4'hC,    32'h0,        0, 1, 1,  0,  1, 32'h30303030, 1));
    vecs.push_back(mk(1, 17'h30, 0, 4'hF, 32'h0,         1, 17'h40, 0, 4'hC,    32'h0,        1, 0, 0,  1,  1, 32'h40404040, 2));
    vecs.push_back(mk(1, 17'h30, 0, 4'hF, 32'h0,         1, 17'h40, 0, 4'hC,    32'h0,        0, 1, 1,  0,  1, 32'h30303030, 3));
    vecs.push_back(mk(1, 17'h30, 0, 4'hF, 32'h0,         1, 17'h40, 0, 4'hC,    32'h0,        1, 0, 0,  1,  1, 32'h40404040, 4));
    vecs.push_back(mk(1, 17'h30, 0, 4'hF, 32'h0,         1, 17'h40, 0, 4'hC,    32'h0,        0, 1, 1,  0,  1, 32'h30303030, 5));
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         0, 17'h00, 0, 4'h0,    32'h0,        0, 0, 0,  1,  1, 32'h40404040, 6));
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         0, 17'h00, 0, 4'h0,    32'h0,        0, 0, 0,  0,  1, 32'h0,        6));
    vecs.push_back(mk(1, 17'h50, 1, 4'hF, 32'hCAFEBABE,  0, 17'h00, 0, 4'h0,    32'h0,        1, 0, 0,  0,  1, 32'h0,        6));
    vecs.push_back(mk(1, 17'h50, 0, 4'hF, 32'h0,         0, 17'h00, 0, 4'h0,    32'h0,        1, 0, 1,  0,  0, 32'h0,        6));
    vecs.push_back(mk(0, 17'h00, 0, 4'h0, 32'h0,         0, 17'h00, 0, 4'h0,    32'h0,        0, 0, 1,  0,  1, 32'hCAFEBABE, 6));

    foreach (vecs[i]) begin
      @(negedge clk);
      rr_p0_req = vecs[i].r0; rr_p0_addr = vecs[i].a0; rr_p0_we = vecs[i].w0;
      rr_p0_be = vecs[i].b0; rr_p0_wdata = vecs[i].d0;
      rr_p1_req = vecs[i].r1; rr_p1_addr = vecs[i].a1; rr_p1_we = vecs[i].w1;
      rr_p1_be = vecs[i].b1; rr_p1_wdata = vecs[i].d1;
      exp_addr = '0; exp_we = 0; exp_be = '0; exp_wd = '0;
      if (vecs[i].g0) begin
        exp_addr = vecs[i].a0; exp_we = vecs[i].w0; exp_be = vecs[i].b0; exp_wd = vecs[i].d0;
      end else if (vecs[i].g1) begin
        exp_addr = vecs[i].a1; exp_we = vecs[i].w1; exp_be = vecs[i].b1; exp_wd = vecs[i].d1;
      end
      #1;
      check($sformatf("v%0d p0_gnt", i), {31'b0, rr_p0_gnt}, {31'b0, vecs[i].g0});
      check($sformatf("v%0d p1_gnt", i), {31'b0, rr_p1_gnt}, {31'b0, vecs[i].g1});
      check($sformatf("v%0d ram_en", i), {31'b0, rr_ram_en}, {31'b0, vecs[i].g0 | vecs[i].g1});
      check($sformatf("v%0d ram_addr", i), {15'b0, rr_ram_addr}, {15'b0, exp_addr});
      check($sformatf("v%0d ram_we", i), {31'b0, rr_ram_we}, {31'b0, exp_we});
      check($sformatf("v%0d ram_be", i), {28'b0, rr_ram_be}, {28'b0, exp_be});
      check($sformatf("v%0d ram_wdata", i), rr_ram_wdata, exp_wd);
      check($sformatf("v%0d p0_rvalid", i), {31'b0, rr_p0_rvalid}, {31'b0, vecs[i].rv0});
      check($sformatf("v%0d p1_rvalid", i), {31'b0, rr_p1_rvalid}, {31'b0, vecs[i].rv1});
      if (vecs[i].chk_rd || !vecs[i].rv0)
        check($sformatf("v%0d p0_rdata", i), rr_p0_rdata, vecs[i].rv0 ? vecs[i].rd : 32'h0);
      if (vecs[i].chk_rd || !vecs[i].rv1)
        check($sformatf("v%0d p1_rdata", i), rr_p1_rdata, vecs[i].rv1 ? vecs[i].rd : 32'h0);
      check($sformatf("v%0d cnt", i), {16'b0, rr_cnt}, {16'b0, vecs[i].cnt});
    end

    // Fixed priority: p0 wins four straight conflicts, p1 gets in once p0 drops
    @(negedge clk);
    idle_rr();
    fp_p0_req = 1; fp_p1_req = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("fp c%0d p0_gnt", k), {31'b0, fp_p0_gnt}, 32'h1);
      check($sformatf("fp c%0d p1_gnt", k), {31'b0, fp_p1_gnt}, 32'h0);
      check($sformatf("fp c%0d ram_addr", k), {15'b0, fp_ram_addr}, 32'h1);
      @(negedge clk);
    end
    fp_p0_req = 0;
    #1;
    check("fp p1_gnt after drop", {31'b0, fp_p1_gnt}, 32'h1);
    check("fp ram_addr after drop", {15'b0, fp_ram_addr}, 32'h2);
    check("fp p0_rvalid", {31'b0, fp_p0_rvalid}, 32'h1);
    check("fp p0_rdata", fp_p0_rdata, 32'hCAFEF00D);
    check("fp cnt", {16'b0, fp_cnt}, 32'h4);
    @(negedge clk);
    fp_p1_req = 0;
    #1;
    check("fp p1_rvalid", {31'b0, fp_p1_rvalid}, 32'h1);
    check("fp p1_rdata", fp_p1_rdata, 32'hCAFEF00D);
    check("fp p0_rvalid off", {31'b0, fp_p0_rvalid}, 32'h0);
    check("fp p0_rdata off", fp_p0_rdata, 32'h0);

    // 4-bit counter: saturates at 15, clear wins over a live conflict
    @(negedge clk);
    st_p0_req = 1; st_p1_req = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("sat cnt after %0d", k), {28'b0, st_cnt}, (k > 15) ? 32'd15 : k);
    end
    st_clr = 1;
    @(negedge clk);
    #1;
    check("sat cnt cleared", {28'b0, st_cnt}, 32'h0);
    st_clr = 0;
    @(negedge clk);
    #1;
    check("sat cnt restart", {28'b0, st_cnt}, 32'h1);
    st_p0_req = 0; st_p1_req = 0;

    // Reset while a response is in flight
    @(negedge clk);
    rr_p0_req = 1; rr_p0_addr = 17'h10; rr_p0_be = 4'hF;
    #1;
    check("mid p0_gnt", {31'b0, rr_p0_gnt}, 32'h1);
    @(posedge clk);
    #1;
    check("mid p0_rvalid before rst", {31'b0, rr_p0_rvalid}, 32'h1);
    rr_p0_req = 0;
    rst = 1;
    #1;
    check("mid p0_rvalid dropped", {31'b0, rr_p0_rvalid}, 32'h0);
    check("mid p0_rdata dropped", rr_p0_rdata, 32'h0);
    check("mid cnt cleared", {16'b0, rr_cnt}, 32'h0);
    @(negedge clk);
    rr_p0_req = 1; rr_p0_addr = 17'h30;
    rr_p1_req = 1; rr_p1_addr = 17'h40; rr_p1_be = 4'hF;
    #1;
    check("rst conflict p0_gnt", {31'b0, rr_p0_gnt}, 32'h1);
    check("rst conflict p1_gnt", {31'b0, rr_p1_gnt}, 32'h0);
    @(negedge clk);
    rst = 0;
    #1;
    check("post-rst p0_gnt", {31'b0, rr_p0_gnt}, 32'h1);
    check("post-rst p1_gnt", {31'b0, rr_p1_gnt}, 32'h0);
    check("post-rst p0_rvalid", {31'b0, rr_p0_rvalid}, 32'h0);
    @(negedge clk);
    #1;
    check("post-rst alt p1_gnt", {31'b0, rr_p1_gnt}, 32'h1);
    check("post-rst p0_rvalid", {31'b0, rr_p0_rvalid}, 32'h1);
    check("post-rst p0_rdata", rr_p0_rdata, 32'h30303030);
    check("post-rst cnt", {16'b0, rr_cnt}, 32'h1);
    idle_rr();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
